// File: rtl/program_loader.sv
// program_loader: assembles little-endian Thumb halfwords from a framed UART byte stream and writes
// them into CPU program memory. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module program_loader #(
   parameter int unsigned INDEX_WIDTH = 32,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   download_program,
   output logic [INDEX_WIDTH-1:0] instruction_index,
   output logic [15:0]            program_in,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   typedef enum logic [3:0] {
      StIdle, StIdxLo, StIdxHi, StCntLo, StCntHi, StDatLo, StDatHi, StWrite, StCheck, StFinish
   } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_t StTail = StCheck;
`else
   localparam state_t StTail = StFinish;
`endif

   state_t                 state_q, state_d;
   logic                   xfer;
   logic [15:0]            idx_q, cnt_q, word_cnt_q;
   logic [15:0]            cnt_in, word_cnt_inc;
   logic [7:0]             dat_lo_q;
   logic                   error_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [15:0]            data_q;

   assign xfer         = in_valid && in_ready;
   assign cnt_in       = {in_data, cnt_q[7:0]};
   assign word_cnt_inc = word_cnt_q + 16'd1;

   assign instruction_index = index_q;
   assign program_in        = data_q;
   assign error             = error_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;
   logic       chk_ok;

   assign chk_ok = (in_data == chk_q);

   // Accumulates every header and payload byte; cleared by the sync byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q <= 8'h00;
      end else if (xfer) begin
         if (state_q == StIdle) begin
            chk_q <= 8'h00;
         end else if (state_q inside {StIdxLo, StIdxHi, StCntLo, StCntHi, StDatLo, StDatHi}) begin
            chk_q <= chk_q ^ in_data;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (xfer && in_data == SYNC_BYTE) state_d = StIdxLo;
         StIdxLo: if (xfer) state_d = StIdxHi;
         StIdxHi: if (xfer) state_d = StCntLo;
         StCntLo: if (xfer) state_d = StCntHi;
         StCntHi: begin
            if (xfer) begin
               if (32'(cnt_in) > MAX_WORDS) state_d = StIdle;
               else if (cnt_in == 16'd0)    state_d = StTail;
               else                         state_d = StDatLo;
            end
         end
         StDatLo: if (xfer) state_d = StDatHi;
         StDatHi: if (xfer) state_d = StWrite;
         StWrite: state_d = (word_cnt_inc == cnt_q) ? StTail : StDatLo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StCheck: if (xfer) state_d = chk_ok ? StFinish : StIdle;
`endif
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready         = 1'b1;
      download_program = 1'b0;
      done             = 1'b0;
      busy             = 1'b1;
      unique case (state_q)
         StIdle: busy = 1'b0;
         StWrite: begin
            in_ready         = 1'b0;
            download_program = 1'b1;
         end
         StFinish: begin
            in_ready = 1'b0;
            done     = 1'b1;
            busy     = 1'b0;
         end
         default: ;
      endcase
   end

   // Header fields, word counter, write address/data and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= 16'd0;
         cnt_q      <= 16'd0;
         word_cnt_q <= 16'd0;
         dat_lo_q   <= 8'h00;
         error_q    <= 1'b0;
         index_q    <= '0;
         data_q     <= 16'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (xfer && in_data == SYNC_BYTE) begin
                  error_q    <= 1'b0;
                  word_cnt_q <= 16'd0;
               end
            end
            StIdxLo: if (xfer) idx_q[7:0]  <= in_data;
            StIdxHi: if (xfer) idx_q[15:8] <= in_data;
            StCntLo: if (xfer) cnt_q[7:0]  <= in_data;
            StCntHi: begin
               if (xfer) begin
                  cnt_q <= cnt_in;
                  if (32'(cnt_in) > MAX_WORDS) error_q <= 1'b1;
               end
            end
            StDatLo: if (xfer) dat_lo_q <= in_data;
            StDatHi: begin
               if (xfer) begin
                  index_q <= INDEX_WIDTH'(idx_q) + INDEX_WIDTH'(word_cnt_q);
                  data_q  <= {in_data, dat_lo_q};
               end
            end
            StWrite: word_cnt_q <= word_cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck: if (xfer && !chk_ok) error_q <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
